data_block_buffer: RTL
======================

Name: data_block_buffer

Overview:
- Parametrised successor to the single-entry load register. Holds up to DEPTH data blocks of WIDTH bits in arrival order.
- Input and output each use a valid/ready handshake, so the producer (key/state loader) and consumer (round datapath) are decoupled and can stall independently.
- Adds occupancy reporting, full/empty flags, a synchronous flush and a sticky error for protocol violations. The old single register had none of these.

Parameters:
- WIDTH, 128, bits per data block; range 8 to 256.
- DEPTH, 4, number of entries; power of two, minimum 2.
- CW, $clog2(DEPTH+1), width of count; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all entries.
- in_valid  input  1  producer presents data_in.
- in_ready  output  1  buffer can accept a block this cycle.
- data_in  input  WIDTH  block to store.
- out_valid  output  1  data_out holds the oldest stored block.
- out_ready  input  1  consumer takes data_out this cycle.
- data_out  output  WIDTH  oldest block; forced 0 when out_valid=0.
- count  output  CW  number of stored blocks, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- err  output  1  sticky: in_valid asserted while full.

Behaviour:
- Reset (rst=1, asynchronous, any time including mid-transfer):
  - write/read pointers = 0, count = 0, all storage = 0, err = 0.
  - Outputs: in_ready=1, out_valid=0, data_out=0, full=0, empty=1.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = !full; it never depends combinationally on out_ready.
  - out_valid = !empty.
- Push: data_in written to mem[wr_ptr] at the edge; wr_ptr wraps DEPTH-1 -> 0.
- Pop: rd_ptr advances at the edge with the same wrap.
- data_out = mem[rd_ptr] when out_valid=1, else 0. Combinational from registered state only.
- Latency: a block pushed at edge N appears on data_out with out_valid=1 from edge N to the next edge. No same-cycle fall-through when empty.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Simultaneous push and pop at count=1:
  - The popped block leaves and the new block becomes the head at the next edge.
  - out_valid stays 1.
- Full:
  - in_valid while full is ignored: no write, pointers and count unchanged.
  - err is set at that edge and holds until rst.
  - A pop while full frees a slot; in_ready=1 from the next edge.
- Empty: out_ready while empty is ignored, with no error.
- Flush:
  - At the edge: pointers=0, count=0.
  - Takes priority over a push or pop in the same cycle; that push is dropped and is not an error.
  - Storage contents need not be cleared, since data_out is masked to 0.
  - err is not cleared by flush.
- Ordering: strict FIFO; no reordering or duplication across any wrap sequence.
- full, empty and count are consistent in every cycle: full == (count==DEPTH), empty == (count==0).

Test Plan:
- Reset then idle:
  - Assert rst for 1ns mid-cycle, release.
  - Required: in_ready=1, out_valid=0, data_out=0, count=0, empty=1, err=0.
- Single push, delayed pop:
  - in_valid=1 with data_in=69 for one edge, out_ready=0.
  - Required: count=1, data_out=69, out_valid=1, held over 3 idle cycles.
  - Then out_ready=1 for one edge. Required: count=0, data_out=0.
- Fill and overflow (DEPTH=4):
  - Push 69, 74, 75, 76. Required: full=1, in_ready=0, count=4.
  - Push 99 with in_valid=1. Required: ignored, err=1, count=4.
  - Pop 4 times. Required: outputs 69, 74, 75, 76 in order; 99 never appears.
- Wrap and simultaneous push/pop:
  - Push 10 blocks while continuously popping. Required: count stays at 1 after the first push.
  - Required: data_out follows inputs in order through pointer wrap; full never asserts.
- Flush priority:
  - With count=3, assert flush together with in_valid=1, data_in=0xAA and out_ready=1.
  - Required next cycle: count=0, empty=1, data_out=0, err unchanged.
  - The next push of 0x55 appears as the head.
- Reset mid-operation:
  - With count=2 and a push in progress, pulse rst between edges.
  - Required: outputs return to reset values immediately (asynchronously); the following push of 0x1234 is read back correctly.

Source files
------------

// File: rtl/data_block_buffer.sv
// Valid/ready FIFO of DEPTH data blocks, WIDTH bits each, with occupancy flags,
// a synchronous flush and a sticky overflow error.
module data_block_buffer #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             err
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             err_q;
    logic             push;
    logic             pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    // Masked so stale storage left behind by a flush is never visible.
    assign data_out  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (in_valid && full && !flush) begin
                err_q <= 1'b1;
            end
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= data_in;
                    wr_ptr_q        <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                if (push && !pop) begin
                    count_q <= count_q + CW'(1);
                end else if (pop && !push) begin
                    count_q <= count_q - CW'(1);
                end
            end
        end
    end
endmodule
